// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed big-endian program image over a byte
// stream, writes it into instruction memory, then sequences cpu reset/run.
module imem_boot_loader #(
   parameter int ADDR_WIDTH  = 10,  // word address width, at most 16
   parameter int SYNC_STAGES = 2    // running_switch synchronizer depth, at least 2
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   input  logic                  running_switch,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_reset_n,
   output logic                  cpu_enable,
   output logic                  load_done,
   output logic                  load_error,
   output logic [15:0]           words_loaded
);

   typedef enum logic [2:0] {
      IDLE,
      HDR_HI,
      HDR_LO,
      DATA,
      READY,
      RUN,
      ERROR
   } state_t;

   localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;

   state_t                 state;
   state_t                 state_next;

   logic [15:0]            len_q;
   logic [15:0]            hdr_len;
   logic [15:0]            word_idx;
   logic [1:0]             byte_idx;
   logic [23:0]            word_buf;
   logic [SYNC_STAGES-1:0] sw_sync_q;
   logic                   sw_sync;
   logic                   accept;
   logic                   last_byte;

   assign rx_ready  = (state == HDR_HI) || (state == HDR_LO) || (state == DATA);
   assign accept    = rx_valid && rx_ready;
   assign hdr_len   = {len_q[15:8], rx_data};
   assign last_byte = (byte_idx == 2'd3) && (word_idx == len_q - 16'd1);
   assign sw_sync   = sw_sync_q[SYNC_STAGES-1];

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         state <= state_next;
      end
   end

   // Next-state decode
   always_comb begin
      // NOTE: default assigned first so no path leaves state_next unassigned,
      // which would otherwise infer a latch.
      state_next = state;
      unique case (state)
         IDLE:   state_next = HDR_HI;
         HDR_HI: if (accept) state_next = HDR_LO;
         HDR_LO: begin
            if (accept) begin
               if (hdr_len == 16'd0)
                  state_next = READY;
               else if (32'(hdr_len) > CAPACITY)
                  state_next = ERROR;
               else
                  state_next = DATA;
            end
         end
         DATA:   if (accept && last_byte) state_next = READY;
         READY:  if (sw_sync) state_next = RUN;
         RUN:    state_next = RUN;
         ERROR:  state_next = ERROR;
         default: state_next = IDLE;
      endcase
   end

   // Run switch synchronizer
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sw_sync_q <= '0;
      end else begin
         sw_sync_q <= {sw_sync_q[SYNC_STAGES-2:0], running_switch};
      end
   end

   // Header capture, word assembly and memory write port
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         len_q        <= '0;
         word_idx     <= '0;
         byte_idx     <= '0;
         word_buf     <= '0;
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= '0;
         words_loaded <= '0;
      end else begin
         imem_we <= 1'b0;
         if (accept) begin
            unique case (state)
               HDR_HI: len_q[15:8] <= rx_data;
               HDR_LO: begin
                  len_q[7:0] <= rx_data;
                  word_idx   <= '0;
                  byte_idx   <= '0;
               end
               DATA: begin
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     imem_we      <= 1'b1;
                     imem_addr    <= word_idx[ADDR_WIDTH-1:0];
                     imem_wdata   <= {word_buf, rx_data};
                     word_idx     <= word_idx + 16'd1;
                     words_loaded <= word_idx + 16'd1;
                  end else begin
                     // Earlier bytes shift up so byte 0 lands in [31:24]
                     word_buf <= {word_buf[15:0], rx_data};
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Cpu sequencing and status flags
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         load_done   <= 1'b0;
         load_error  <= 1'b0;
         cpu_reset_n <= 1'b0;
         cpu_enable  <= 1'b0;
      end else begin
         load_done   <= load_done || (state == READY);
         load_error  <= (state_next == ERROR);
         cpu_reset_n <= (state_next == RUN);
         cpu_enable  <= (state == RUN) && sw_sync;
      end
   end

endmodule
